// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the framed program loader.
package loader_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;
  localparam logic [7:0] END_BYTE   = 8'h5A;
  localparam logic [7:0] ESC_BYTE   = 8'hDB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_ESC,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/byte_readout_mux.sv
// Registered byte-wide debug readout across NCH packed monitored words.
module byte_readout_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 2,
  localparam int unsigned BPW    = DATA_W / 8,
  localparam int unsigned LANE_W = $clog2(BPW),
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic [NCH*DATA_W-1:0] mon_data_i,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [LANE_W-1:0]     byte_sel,
  output logic [7:0]            value_o
);

  logic [DATA_W-1:0] sel_word;
  logic [7:0]        value_d;
  logic [7:0]        value_q;

  // Channel select; an out-of-range channel leaves the word at zero.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_sel == CH_W'(k)) begin
        sel_word = mon_data_i[k*DATA_W +: DATA_W];
      end
    end
    value_d = 8'(sel_word >> {byte_sel, 3'b000});
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-serial program image loader with checksum, length/overflow
// checks and a registered debug readout.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NCH    = 2,
  localparam int unsigned BPW    = DATA_W / 8,
  localparam int unsigned LANE_W = $clog2(BPW),
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  sys_start,
  output logic                  load_err,
  output logic [ADDR_W:0]       words_loaded,
  input  logic [NCH*DATA_W-1:0] mon_data_i,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [LANE_W-1:0]     byte_sel,
  output logic [7:0]            value_o
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);
  localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [7:0]          sum_q, sum_d;
  logic                pend_vld_q, pend_vld_d;
  logic [7:0]          pend_q, pend_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                sys_start_q, sys_start_d;
  logic                load_err_q, load_err_d;
  logic                restart;
  logic                literal;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      wl_q        <= '0;
      sum_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sys_start_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      wl_q        <= wl_d;
      sum_q       <= sum_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sys_start_q <= sys_start_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    wl_d        = wl_q;
    sum_d       = sum_q;
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    restart     = 1'b0;
    literal     = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        S_IDLE: restart = (in_byte == START_BYTE);
        S_RECV: begin
          if (in_byte == ESC_BYTE) begin
            state_d = S_ESC;
          end else if (in_byte == START_BYTE) begin
            restart = 1'b1;
          end else if (in_byte == END_BYTE) begin
            // The pending byte is the checksum, already folded into the sum.
            if (pend_vld_q && (lane_q == '0) && (sum_q == 8'h00)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ERR;
            end
          end else begin
            literal = 1'b1;
          end
        end
        S_ESC: begin
          literal = 1'b1;
          state_d = S_RECV;
        end
        S_ERR:   restart = (in_byte == START_BYTE);
        default: ;
      endcase
    end

    if (restart) begin
      state_d    = S_RECV;
      lane_d     = '0;
      wl_d       = '0;
      sum_d      = '0;
      pend_vld_d = 1'b0;
    end

    // One-byte delay: the previous literal moves into the assembler.
    if (literal) begin
      sum_d      = sum_q + in_byte;
      pend_d     = in_byte;
      pend_vld_d = 1'b1;
      if (pend_vld_q) begin
        asm_d = {pend_q, asm_q[DATA_W-1:8]};
        if (lane_q == LAST_LANE) begin
          lane_d = '0;
          if (wl_q == CAPACITY) begin
            state_d = S_ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wl_q[ADDR_W-1:0];
            mem_wdata_d = asm_d;
            wl_d        = wl_q + 1'b1;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
    end

    sys_start_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERR);
  end

  byte_readout_mux #(
    .DATA_W (DATA_W),
    .NCH    (NCH)
  ) u_readout (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .mon_data_i (mon_data_i),
    .ch_sel     (ch_sel),
    .byte_sel   (byte_sel),
    .value_o    (value_o)
  );

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign sys_start    = sys_start_q;
  assign load_err     = load_err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame vector table, write scoreboard
// and hand-written reset/readout sequences.
module tb_program_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned NCH    = 2;

  logic                  sys_clk = 1'b0;
  logic                  sys_reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic [7:0]            in_byte = '0;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  sys_start;
  logic                  load_err;
  logic [ADDR_W:0]       words_loaded;
  logic [NCH*DATA_W-1:0] mon_data_i = '0;
  logic                  ch_sel = 1'b0;
  logic [1:0]            byte_sel = '0;
  logic [7:0]            value_o;

  program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH)) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .sys_start    (sys_start),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .mon_data_i   (mon_data_i),
    .ch_sel       (ch_sel),
    .byte_sel     (byte_sel),
    .value_o      (value_o)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Frame bytes are right-aligned: byte i sits at [(len-1-i)*8 +: 8].
  typedef struct {
    logic [191:0] frame;
    int           len;
    bit           do_reset;
    int           nwr;
    logic [127:0] wdata;
    logic         start;
    logic         err;
    int           wl;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every memory write is matched against the scoreboard queue.
  always @(negedge sys_clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(w.addr));
        check("write_data", 64'(mem_wdata), 64'(w.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{192'hA513000000ED5A, 7, 1'b1, 1, 128'h13, 1'b1, 1'b0, 1};
    vecs[1]  = '{192'hA5DB5A000000A65A, 8, 1'b1, 1, 128'h5A, 1'b1, 1'b0, 1};
    vecs[2]  = '{192'hA513000000EE5A, 7, 1'b1, 1, 128'h13, 1'b0, 1'b1, 1};
    vecs[3]  = '{192'hA513000000ED5A, 7, 1'b0, 1, 128'h13, 1'b1, 1'b0, 1};
    vecs[4]  = '{192'hA5130000ED5A, 6, 1'b1, 0, 128'h0, 1'b0, 1'b1, 0};
    vecs[5]  = '{192'hA5_01000000_02000000_03000000_04000000_05000000_F1_5A, 23, 1'b1, 4,
                 {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b1, 4};
    vecs[6]  = '{192'hA578563412DBDBDBA500006C5A, 13, 1'b1, 2,
                 {64'h0, 32'h0000A5DB, 32'h12345678}, 1'b1, 1'b0, 2};
    vecs[7]  = '{192'h0011A51313A522000000DE5A, 12, 1'b1, 1, 128'h22, 1'b1, 1'b0, 1};
    vecs[8]  = '{192'hA55A, 2, 1'b1, 0, 128'h0, 1'b0, 1'b1, 0};
    vecs[9]  = '{192'hA5A6000000DB5A5A, 8, 1'b1, 1, 128'hA6, 1'b1, 1'b0, 1};
    vecs[10] = '{192'hA501000000FF5A, 7, 1'b0, 0, 128'h0, 1'b1, 1'b0, 1};

    // Reset state, with readout pointed at a non-zero lane.
    mon_data_i = {32'h11223344, 32'hAABBCCDD};
    ch_sel     = 1'b1;
    byte_sel   = 2'd2;
    sys_reset  = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_sys_start", 64'(sys_start), 64'(0));
    check("rst_load_err", 64'(load_err), 64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    check("rst_value_o", 64'(value_o), 64'(0));
    sys_reset = 1'b0;
    @(negedge sys_clk);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].do_reset) do_reset();
      for (int j = 0; j < vecs[v].nwr; j++) begin
        wr_t w;
        w.addr = ADDR_W'(j);
        w.data = vecs[v].wdata[j*32 +: 32];
        exp_q.push_back(w);
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        send_byte(vecs[v].frame[(vecs[v].len-1-i)*8 +: 8]);
      end
      @(negedge sys_clk);
      @(negedge sys_clk);
      check($sformatf("v%0d_sys_start", v), 64'(sys_start), 64'(vecs[v].start));
      check($sformatf("v%0d_load_err", v), 64'(load_err), 64'(vecs[v].err));
      check($sformatf("v%0d_words_loaded", v), 64'(words_loaded), 64'(vecs[v].wl));
      check($sformatf("v%0d_missing_writes", v), 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end

    // Reset mid-frame: no write afterwards and the loader is back in IDLE.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h13);
    send_byte(8'h00);
    in_valid  = 1'b1;
    in_byte   = 8'h00;
    sys_reset = 1'b1;
    @(negedge sys_clk);
    in_valid  = 1'b0;
    sys_reset = 1'b0;
    @(negedge sys_clk);
    check("midrst_mem_we", 64'(mem_we), 64'(0));
    check("midrst_words_loaded", 64'(words_loaded), 64'(0));
    check("midrst_sys_start", 64'(sys_start), 64'(0));
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hED);
    send_byte(8'h5A);
    @(negedge sys_clk);
    check("midrst_idle_start", 64'(sys_start), 64'(0));
    check("midrst_idle_err", 64'(load_err), 64'(0));
    check("midrst_idle_wl", 64'(words_loaded), 64'(0));

    // Readout lanes, one cycle after each select change.
    for (int r = 0; r < 4; r++) begin
      logic       cs [4];
      logic [1:0] bs [4];
      logic [7:0] ev [4];
      cs = '{1'b1, 1'b0, 1'b0, 1'b1};
      bs = '{2'd2, 2'd0, 2'd3, 2'd0};
      ev = '{8'h22, 8'hDD, 8'hAA, 8'h44};
      ch_sel   = cs[r];
      byte_sel = bs[r];
      @(negedge sys_clk);
      check($sformatf("readout_%0d", r), 64'(value_o), 64'(ev[r]));
    end
    mon_data_i = {32'h11223344, 32'h0055_0000};
    ch_sel     = 1'b0;
    byte_sel   = 2'd2;
    @(negedge sys_clk);
    check("readout_data_change", 64'(value_o), 64'(8'h55));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Parameterised boot-time front end for the pipelined RISC-V core: receives a framed, byte-serial program image, assembles bytes into DATA_W-bit instruction words and writes them into instruction memory. It verifies a checksum and releases `sys_start` to the pipeline only after a clean load. It also provides a registered byte-wide debug readout across NCH monitored words. It replaces the fixed start/end-marker loader and the fixed 4-way `value_o` mux with escaped framing, checksum, length and overflow checks, and N-channel readout.

## Interface
Parameters:
- DATA_W, 32, instruction word width; must be a multiple of 8 and at least 16; BPW = DATA_W/8.
- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words.
- NCH, 2, number of monitored words for readout (e.g. register file, data memory); at least 1.

Ports (clock and reset first):
- sys_clk, in, 1, the single clock; all logic is on the rising edge.
- sys_reset, in, 1, synchronous, active-high reset.
- in_valid, in, 1, `in_byte` is valid this cycle; every valid byte is accepted, with no backpressure.
- in_byte, in, 8, serial image byte.
- mem_we, out, 1, instruction-memory write strobe (one-cycle pulse).
- mem_addr, out, ADDR_W, word address.
- mem_wdata, out, DATA_W, assembled word.
- sys_start, out, 1, pipeline enable; sticky high after a good load.
- load_err, out, 1, sticky load-failure flag.
- words_loaded, out, ADDR_W+1, count of words written in the current frame.
- mon_data_i, in, NCH*DATA_W, packed monitored words; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_sel, in, max(1,clog2(NCH)), readout channel.
- byte_sel, in, clog2(BPW), readout byte lane; lane 0 = bits [7:0].
- value_o, out, 8, registered readout byte.

## Operation
- The frame format is START (0xA5), then the escaped payload, then the escaped checksum byte, then END (0x5A).
- Escaping: ESC (0xDB) makes the next byte literal, whatever its value. The literals 0xA5, 0x5A and 0xDB must be escaped inside the frame.
- Checksum rule: (sum of all payload bytes + checksum byte) mod 256 = 0.
- FSM states: IDLE, RECV, ESC, DONE, ERR.
  - IDLE: an unescaped START moves to RECV and clears the byte counter, word counter, running sum and pending flag. All other bytes are ignored.
  - RECV: ESC moves to ESC. START restarts the frame, clearing the same state as in IDLE; already-written words stay in memory. END runs the frame check. Any other byte is a literal.
  - ESC: the next valid byte is a literal, then the state returns to RECV.
  - DONE: all input is ignored until reset.
  - ERR: START restarts the frame and clears `load_err`; other bytes are ignored.
- Literal handling, with a one-byte delay so that the checksum byte is never written:
  - Each literal is added to the running sum.
  - If a pending byte exists, it is shifted into the word assembler.
  - The new literal then becomes the pending byte.
- Word assembly is little-endian: the first byte lands in [7:0].
  - When BPW bytes have been assembled, the word is written at address `words_loaded`, and `words_loaded` increments.
  - A write when `words_loaded` = 2^ADDR_W is suppressed and the loader goes to ERR.
- END check: the pending byte is the checksum. The loader goes to DONE only if all of these hold; otherwise it goes to ERR:
  - a pending byte exists;
  - the assembled-byte count is a multiple of BPW;
  - the running sum is 0 mod 256.
- Outputs by state:
  - DONE: `sys_start` = 1 and `load_err` = 0.
  - ERR: `sys_start` = 0 and `load_err` = 1.
- Readout: on every cycle, `value_o` is registered from byte lane `byte_sel` of channel `ch_sel`. An out-of-range `ch_sel` gives 0x00.

## Timing
- Reset values:
  - state IDLE; `mem_we`, `sys_start`, `load_err` = 0;
  - `mem_addr` and `mem_wdata` = 0; `words_loaded` = 0; `value_o` = 0x00;
  - all counters, the running sum and the pending flag cleared.
- Reset mid-frame aborts the frame immediately. There are no writes in the cycle after reset.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid for one cycle, the cycle after the `in_valid` cycle whose byte pushes the final byte of a word out of the pending slot.
- `sys_start` and `load_err` update in the cycle after END is accepted.
- At most one memory write per cycle; back-to-back valid bytes are supported at full rate.
- Readout latency is 1 cycle from a `ch_sel`/`byte_sel`/`mon_data_i` change, and it is independent of the FSM.

## Structure
- Shared package `loader_pkg`:
  - byte constants START = 8'hA5, END = 8'h5A, ESC = 8'hDB;
  - FSM state enum (IDLE, RECV, ESC, DONE, ERR).
- One sub-module, `byte_readout_mux` (parameters DATA_W and NCH; registered output). The FSM, word assembler and checksum stay in `program_loader`.

## Test plan
- Clean load: A5 13 00 00 00 ED 5A → one write, addr 0, data 0x00000013. Then `sys_start` = 1, `load_err` = 0, `words_loaded` = 1.
- Escaping: A5 DB 5A 00 00 00 A6 5A → write of 0x0000005A at addr 0; `sys_start` = 1.
- Bad checksum: A5 13 00 00 00 EE 5A → one write, then `load_err` = 1 and `sys_start` = 0. A following good frame clears `load_err`.
- Short word: A5 13 00 00 ED 5A → no write; ERR.
- Overflow with ADDR_W = 2: five words sent → four writes (addrs 0–3), then ERR before END.
- Reset mid-frame: assert reset after A5 13 00 → no write, state IDLE. Readout with NCH = 2, `mon_data_i` = {0x11223344, 0xAABBCCDD}, `ch_sel` = 1, `byte_sel` = 2 → `value_o` = 0x22 one cycle later.
